// File: rtl/rom_stream_pkg.sv
// Shared types and helpers for the ROM streamer.
//   rs_state_t  : streamer FSM state encoding
//   fifo_ptr_w  : pointer width for a power-of-two FIFO depth
package rom_stream_pkg;

    typedef enum logic [1:0] {
        RS_IDLE  = 2'd0,
        RS_RUN   = 2'd1,
        RS_DRAIN = 2'd2
    } rs_state_t;

    localparam int RS_FIFO_DEPTH_DEF = 4;
    localparam int RS_FIFO_PTR_W_DEF = $clog2(RS_FIFO_DEPTH_DEF);

    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, power-of-two depth, synchronous active-high reset.
//   clk, rst          : clock and reset
//   push, wr_data     : write request and data
//   pop, rd_data      : read request and head-of-queue data (first-word fall-through)
//   full, empty, count: occupancy status
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo
    import rom_stream_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4,
    localparam int PTR_W = fifo_ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the read side is qualified by empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/rom_streamer.sv
// Sequential ROM read engine feeding a valid/ready stream.
//   clk, rst              : clock, synchronous active-high reset
//   start, base_addr,
//   length                : transfer launch (sampled in IDLE only)
//   busy, done            : transfer in progress / one-cycle completion pulse
//   rom_ena, rom_addr,
//   rom_dout              : synchronous ROM port (data one cycle after ena)
//   m_valid, m_ready,
//   m_data, m_last        : output stream with backpressure
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RS_IDLE  | waiting for start; no ROM reads
// RS_RUN   | issuing ROM reads whenever the output buffer has credit
// RS_DRAIN | all reads issued; emptying buffer until the m_last handshake
module rom_streamer
    import rom_stream_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              rom_ena,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    localparam int PTR_W = fifo_ptr_w(FIFO_DEPTH);
    localparam logic [PTR_W+1:0] DEPTH_L = (PTR_W+2)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]  CNT_ONE = (ADDR_W+1)'(1);

    rs_state_t          state;
    rs_state_t          state_nx;
    logic [ADDR_W:0]    len_q;
    logic [ADDR_W:0]    issued;
    logic               inflight;
    logic               inflight_last;
    logic               issue_last;
    logic               pop;
    logic               last_pop;
    logic               launch;
    logic               zero_start;
    logic [PTR_W+1:0]   occupancy;

    logic               fifo_empty;
    logic               fifo_full_unused;
    logic [PTR_W:0]     fifo_count;
    logic [DATA_W:0]    fifo_rd;

    assign m_valid  = ~fifo_empty;
    assign pop      = m_valid & m_ready;
    assign last_pop = pop & fifo_rd[DATA_W];
    assign m_data   = fifo_empty ? '0 : fifo_rd[DATA_W-1:0];
    assign m_last   = ~fifo_empty & fifo_rd[DATA_W];
    assign busy     = (state != RS_IDLE);

    assign launch     = (state == RS_IDLE) & start & (length != '0);
    assign zero_start = (state == RS_IDLE) & start & (length == '0);
    assign issue_last = (issued == len_q - CNT_ONE);

    // Words buffered plus the one still inside the ROM, less the word leaving
    // this cycle. Keeping this below depth means every capture has a slot.
    assign occupancy = (PTR_W+2)'(fifo_count) + (PTR_W+2)'(inflight) - (PTR_W+2)'(pop);

    always_ff @(posedge clk) begin
        if (rst) state <= RS_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        rom_ena  = 1'b0;
        case (state)
            RS_IDLE: begin
                if (launch) state_nx = RS_RUN;
            end
            RS_RUN: begin
                if (occupancy < DEPTH_L) begin
                    rom_ena = 1'b1;
                    if (issue_last) state_nx = RS_DRAIN;
                end
            end
            RS_DRAIN: begin
                if (last_pop) state_nx = RS_IDLE;
            end
            default: state_nx = RS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr      <= '0;
            len_q         <= '0;
            issued        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
        end else begin
            inflight      <= rom_ena;
            inflight_last <= rom_ena & issue_last;
            done          <= zero_start | ((state == RS_DRAIN) & last_pop);
            if (launch) begin
                rom_addr <= base_addr;
                len_q    <= length;
                issued   <= '0;
            end else if (rom_ena) begin
                // Address wraps naturally at the ROM size.
                rom_addr <= rom_addr + ADDR_W'(1);
                issued   <= issued + CNT_ONE;
            end
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (inflight),
        .wr_data ({inflight_last, rom_dout}),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full_unused),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_rom_streamer.sv
module tb_rom_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sel;
    logic [13:0] base;
    logic [14:0] length;
    logic        m_ready;

    always #5 clk = ~clk;

    // DUT A: 14-bit ROM, DUT B: 4-bit ROM for wrap / full-ROM cases.
    logic        a_start, a_busy, a_done, a_ena, a_valid, a_last;
    logic [13:0] a_addr;
    logic [7:0]  a_dout, a_data;
    logic        b_start, b_busy, b_done, b_ena, b_valid, b_last;
    logic [3:0]  b_addr;
    logic [7:0]  b_dout, b_data;

    assign a_start = start & ~sel;
    assign b_start = start & sel;

    rom_streamer #(.ADDR_W(14), .DATA_W(8), .FIFO_DEPTH(4)) u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .base_addr(base), .length(length),
        .busy(a_busy), .done(a_done), .rom_ena(a_ena), .rom_addr(a_addr),
        .rom_dout(a_dout), .m_valid(a_valid), .m_ready(m_ready),
        .m_data(a_data), .m_last(a_last)
    );

    rom_streamer #(.ADDR_W(4), .DATA_W(8), .FIFO_DEPTH(4)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .base_addr(base[3:0]), .length(length[4:0]),
        .busy(b_busy), .done(b_done), .rom_ena(b_ena), .rom_addr(b_addr),
        .rom_dout(b_dout), .m_valid(b_valid), .m_ready(m_ready),
        .m_data(b_data), .m_last(b_last)
    );

    // ROM images: byte[i] = i (low 8 bits)
    always @(posedge clk) begin
        if (a_ena) a_dout <= a_addr[7:0];
        if (b_ena) b_dout <= {4'd0, b_addr};
    end

    logic        obs_busy, obs_done, obs_ena, obs_valid, obs_last;
    logic [13:0] obs_addr;
    logic [7:0]  obs_data;
    assign obs_busy  = sel ? b_busy  : a_busy;
    assign obs_done  = sel ? b_done  : a_done;
    assign obs_ena   = sel ? b_ena   : a_ena;
    assign obs_addr  = sel ? {10'd0, b_addr} : a_addr;
    assign obs_valid = sel ? b_valid : a_valid;
    assign obs_data  = sel ? b_data  : a_data;
    assign obs_last  = sel ? b_last  : a_last;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: expected {last, data} words and expected ROM addresses.
    logic [8:0]  exp_q[$];
    logic [13:0] addr_q[$];

    task automatic push_expect(input logic s, input logic [13:0] b, input int n);
        int mask, a;
        mask = s ? 15 : 16383;
        for (int i = 0; i < n; i++) begin
            a = (int'(b) + i) & mask;
            exp_q.push_back({(i == n - 1), 8'(a & 255)});
            addr_q.push_back(14'(a));
        end
    endtask

    // Negedge monitor: stream words, addresses, credit rule, stall stability, done.
    int         iss_cnt = 0;
    int         hs_cnt = 0;
    logic       done_due = 1'b0;
    logic       hold_v = 1'b0;
    logic [8:0] hold_d;

    always @(negedge clk) begin
        int         occ;
        logic       hs;
        logic       dn;
        logic [8:0] e;
        logic [13:0] ea;
        if (rst) begin
            exp_q.delete();
            addr_q.delete();
            iss_cnt  = 0;
            hs_cnt   = 0;
            done_due = 1'b0;
            hold_v   = 1'b0;
        end else begin
            hs = obs_valid & m_ready;
            dn = 1'b0;
            if (obs_done || done_due) check("done_pulse", obs_done, done_due);
            if (obs_ena) begin
                occ = iss_cnt - hs_cnt - int'(hs);
                check("credit_ok", occ < 4, 1);
                if (addr_q.size() == 0) check("addr_q_size", addr_q.size(), 1);
                else begin
                    ea = addr_q.pop_front();
                    check("rom_addr", obs_addr, ea);
                end
                iss_cnt++;
            end
            if (hold_v) begin
                check("stall_valid", obs_valid, 1);
                check("stall_word", {obs_last, obs_data}, hold_d);
            end
            hold_v = obs_valid & ~m_ready;
            hold_d = {obs_last, obs_data};
            if (hs) begin
                if (exp_q.size() == 0) check("word_q_size", exp_q.size(), 1);
                else begin
                    e = exp_q.pop_front();
                    check("m_word", {obs_last, obs_data}, e);
                    if (e[8]) dn = 1'b1;
                end
                hs_cnt++;
            end
            if (start && !obs_busy && length == 15'd0) dn = 1'b1;
            done_due = dn;
        end
    end

    typedef struct {
        logic        sel;
        logic [13:0] base;
        logic [14:0] len;
        int          mode;       // 0: ready=1, 1: pattern 1,0,0,1,1,0, 2: random
        logic [7:0]  exp_first;
        logic [7:0]  exp_last;
    } vec_t;

    vec_t vecs[6];

    function automatic logic ready_for(input int mode, input int cyc);
        case (mode)
            0: return 1'b1;
            1: case (cyc % 6)
                   0, 3, 4: return 1'b1;
                   default: return 1'b0;
               endcase
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic run_xfer(input int k);
        int         edges, gaps, cyc;
        logic       seen, got_done;
        logic [7:0] fdat, ldat;
        sel = vecs[k].sel;
        push_expect(vecs[k].sel, vecs[k].base, int'(vecs[k].len));
        base    = vecs[k].base;
        length  = vecs[k].len;
        start   = 1'b1;
        m_ready = ready_for(vecs[k].mode, 0);
        step();
        start = 1'b0;
        edges = 1; gaps = 0; cyc = 1; seen = 1'b0; got_done = 1'b0;
        fdat = 8'h00; ldat = 8'h00;
        for (int i = 0; i < 400 && !got_done; i++) begin
            if (obs_done) got_done = 1'b1;
            else begin
                if (obs_valid && !seen) begin
                    seen = 1'b1;
                    check("first_valid_latency", edges, 3);
                    fdat = obs_data;
                end else if (seen && !obs_valid) gaps++;
                if (obs_valid && obs_last) ldat = obs_data;
                m_ready = ready_for(vecs[k].mode, cyc);
                cyc++;
                step();
                edges++;
            end
        end
        check("xfer_done_seen", got_done, 1);
        check("first_data", fdat, vecs[k].exp_first);
        check("last_data", ldat, vecs[k].exp_last);
        check("words_left", exp_q.size(), 0);
        check("addrs_left", addr_q.size(), 0);
        if (vecs[k].mode == 0) check("stream_gaps", gaps, 0);
        step();
    endtask

    initial begin
        vecs[0] = '{sel:1'b0, base:14'h0010, len:15'd4,  mode:0, exp_first:8'h10, exp_last:8'h13};
        vecs[1] = '{sel:1'b0, base:14'h0000, len:15'd16, mode:1, exp_first:8'h00, exp_last:8'h0F};
        vecs[2] = '{sel:1'b1, base:14'h000E, len:15'd4,  mode:0, exp_first:8'h0E, exp_last:8'h01};
        vecs[3] = '{sel:1'b1, base:14'h0005, len:15'd16, mode:0, exp_first:8'h05, exp_last:8'h04};
        vecs[4] = '{sel:1'b0, base:14'h3FFE, len:15'd3,  mode:2, exp_first:8'hFE, exp_last:8'h00};
        vecs[5] = '{sel:1'b0, base:14'h01F0, len:15'd20, mode:2, exp_first:8'hF0, exp_last:8'h03};

        rst = 1'b1; start = 1'b0; sel = 1'b0; base = '0; length = '0; m_ready = 1'b0;
        repeat (3) step();
        check("rst_busy", obs_busy, 0);
        check("rst_done", obs_done, 0);
        check("rst_rom_ena", obs_ena, 0);
        check("rst_rom_addr", obs_addr, 0);
        check("rst_m_valid", obs_valid, 0);
        check("rst_m_last", obs_last, 0);
        check("rst_m_data", obs_data, 0);
        rst = 1'b0;
        step();

        for (int k = 0; k < 5; k++) run_xfer(k);

        // Zero-length start: done next cycle, never busy.
        sel = 1'b0; base = 14'h0123; length = 15'd0; start = 1'b1;
        step();
        start = 1'b0;
        check("zl_done", obs_done, 1);
        check("zl_busy", obs_busy, 0);
        check("zl_rom_ena", obs_ena, 0);
        step();
        check("zl_done_clear", obs_done, 0);
        check("zl_busy_after", obs_busy, 0);

        // Start while busy must not disturb base or length.
        push_expect(1'b0, 14'h0020, 6);
        base = 14'h0020; length = 15'd6; m_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        base = 14'h0300; length = 15'd2; start = 1'b1;
        step();
        start = 1'b0;
        begin
            logic got;
            got = 1'b0;
            for (int i = 0; i < 100 && !got; i++) begin
                if (obs_done) got = 1'b1;
                else step();
            end
            check("ign_done_seen", got, 1);
        end
        check("ign_words_left", exp_q.size(), 0);
        step();
        check("ign_idle", obs_busy, 0);

        // Reset with two words buffered and one in flight.
        push_expect(1'b0, 14'h0040, 8);
        base = 14'h0040; length = 15'd8; m_ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        check("pre_rst_valid", obs_valid, 1);
        check("pre_rst_busy", obs_busy, 1);
        rst = 1'b1;
        step();
        check("mid_rst_busy", obs_busy, 0);
        check("mid_rst_done", obs_done, 0);
        check("mid_rst_rom_ena", obs_ena, 0);
        check("mid_rst_rom_addr", obs_addr, 0);
        check("mid_rst_m_valid", obs_valid, 0);
        check("mid_rst_m_last", obs_last, 0);
        check("mid_rst_m_data", obs_data, 0);
        rst = 1'b0;
        m_ready = 1'b1;
        step();
        check("post_rst_done", obs_done, 0);
        step();
        check("post_rst_valid", obs_valid, 0);

        run_xfer(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rom_streamer.md
Name: rom_streamer

Overview:
- Sequential-read engine that sits directly upstream of the synchronous plain ROM.
- Drives the ROM's enable and address, and captures its registered output, which appears one cycle after the enable.
- Re-emits the captured words as a valid/ready stream with backpressure.
- Used for boot-copy of ROM into RAM and for tile/character fetch. Never loses or duplicates a word under arbitrary m_ready stalls.

Parameters:
- ADDR_W, 14, ROM address width; must match the attached ROM.
- DATA_W, 8, ROM word width.
- FIFO_DEPTH, 4, output buffer entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  launch a transfer; sampled only in IDLE
- base_addr  in  ADDR_W  first ROM address; latched on start
- length  in  ADDR_W+1  word count, 0 to 2^ADDR_W; latched on start
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer completion
- rom_ena  out  1  to ROM ena
- rom_addr  out  ADDR_W  to ROM addr
- rom_dout  in  DATA_W  from ROM dout; valid the cycle after rom_ena=1
- m_valid  out  1  stream word available
- m_ready  in  1  consumer accepts
- m_data  out  DATA_W  stream word
- m_last  out  1  marks the final word of a transfer

Behaviour:
- Reset values: busy=0, done=0, rom_ena=0, rom_addr=0, m_valid=0, m_last=0, m_data=0. FIFO, in-flight flag and counters are cleared. Reset mid-transfer aborts the transfer immediately; no done pulse.
- State machine, IDLE / RUN / DRAIN:
  - IDLE: start=1 with length≠0 latches base_addr and length, then moves to RUN.
  - IDLE: start=1 with length=0 pulses done on the next cycle and stays in IDLE.
  - RUN: moves to DRAIN on the cycle the last ROM read issues.
  - DRAIN: on the handshake of the m_last word, returns to IDLE and pulses done in the following cycle.
- busy=1 exactly while in RUN or DRAIN. start is ignored while busy.
- Issue rule, RUN only: rom_ena=1 when (fifo_count + inflight − pop) < FIFO_DEPTH.
  - pop = m_valid & m_ready.
  - inflight = registered copy of the previous cycle's rom_ena.
  - Each issue increments rom_addr and the issued count.
- rom_addr wraps modulo 2^ADDR_W. Example: base 0x3FFE, length 3 reads 0x3FFE, 0x3FFF, 0x0000.
- rom_ena=0 in IDLE and DRAIN. rom_addr holds its value when not issuing.
- Capture: when inflight=1, rom_dout is pushed into the FIFO that cycle. Because the ROM holds its output when ena is low, capture happens only on inflight cycles.
- The capture rule guarantees the FIFO never overflows. A simultaneous push and pop on a full FIFO is legal, and count stays unchanged.
- m_last is stored per entry. It is set on the entry whose issue index equals length−1.
- Output follows AXI-style rules: once m_valid=1, m_data and m_last hold stable until the handshake.
- Latency: start sampled at edge E0 gives rom_ena=1 after E0, the FIFO push at E2, and m_valid=1 after E2.
- Throughput: with m_ready held at 1, one word per cycle sustained.
- Full-ROM transfer, length=2^ADDR_W, is legal. It reads every address once, starting at base.
- Internal counters are ADDR_W+1 bits wide.

Decomposition:
- Package rom_stream_pkg holds:
  - the state enum, rs_state_t {RS_IDLE, RS_RUN, RS_DRAIN};
  - a localparam helper for the FIFO pointer width, $clog2(FIFO_DEPTH).
- One sub-module: sync_fifo.
  - Parameterised width (DATA_W+1, to carry data plus last) and depth.
  - Same clk and rst convention.
  - Outputs: full, empty, count.
- The top level contains the FSM, address counter, issue/credit logic and inflight register.

Test Plan:
1. Basic transfer: ROM image with byte[i]=i; base 0x0010, length 4, m_ready=1.
   Required: m_data 0x10, 0x11, 0x12, 0x13 on consecutive cycles; first m_valid 3 cycles after start; m_last only on 0x13; done one cycle after the last handshake.
2. Backpressure: base 0, length 16; m_ready toggles with pattern 1,0,0,1,1,0.
   Required: all 16 words in order, none duplicated; rom_ena never asserted when FIFO plus inflight reaches FIFO_DEPTH; data stable while stalled.
3. Wrap-around: ADDR_W=4, base 0xE, length 4.
   Required: rom_addr sequence 0xE, 0xF, 0x0, 0x1; data is bytes 14, 15, 0, 1.
4. Zero length and ignored start: start with length=0 gives done after 1 cycle and busy stays 0. A start pulse mid-transfer changes neither base nor length.
5. Reset mid-operation: assert rst with 2 words buffered and 1 inflight.
   Required: next cycle all outputs at reset values, no done; a new transfer afterwards delivers correct data from its own base.
6. Full-ROM transfer: ADDR_W=4, length 16, base 0x5, m_ready=1.
   Required: 16 words 5..15, 0..4 with no gaps; m_last on word 4.
